// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/LSU requesters, the memory-port arbiter and the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requesters plus the memory side.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic          d_we;
   logic [3:0]    d_be;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Optional grant timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus,
   output logic              sel,
   output logic              busy,
   output logic              err
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t state_r, state_s;
   logic   last_d_r, last_d_s;
   logic   sel_r, sel_s;
   logic   granted_s;
   logic   tmo_s;
   logic   done_s;

   assign granted_s = (state_r != IDLE);
   assign done_s    = granted_s && (bus.mem_ack || tmo_s);

`ifdef ARB_TIMEOUT_EN
   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);
   logic [CW-1:0] tmo_cnt_r;

   // cycles the current grant has waited without mem_ack
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt_r <= {CW{1'b0}};
      end else if (!granted_s || done_s) begin
         tmo_cnt_r <= {CW{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + CW'(1);
      end
   end

   assign tmo_s = granted_s && !bus.mem_ack && (tmo_cnt_r == TMO_MAX);
`else
   logic unused_tmo_s;
   assign unused_tmo_s = (TIMEOUT != 0);
   assign tmo_s        = 1'b0;
`endif

   // grant state, last-served requester and registered mux select
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         last_d_r <= 1'b1;
         sel_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         last_d_r <= last_d_s;
         sel_r    <= sel_s;
      end
   end

   // next state: ties go to whoever was not served last; a grant ends only on ack or timeout
   always_comb begin
      state_s  = state_r;
      last_d_s = last_d_r;
      sel_s    = sel_r;
      case (state_r)
         IDLE: begin
            if (bus.if_req && (!bus.d_req || last_d_r)) begin
               state_s = GRANT_I;
               sel_s   = 1'b0;
            end else if (bus.d_req) begin
               state_s = GRANT_D;
               sel_s   = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         GRANT_I: begin
            if (done_s) begin
               state_s  = IDLE;
               last_d_s = 1'b0;
            end else begin
               state_s = GRANT_I;
            end
         end
         GRANT_D: begin
            if (done_s) begin
               state_s  = IDLE;
               last_d_s = 1'b1;
            end else begin
               state_s = GRANT_D;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // port mux and requester responses; acks are suppressed while reset is asserted
   always_comb begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = 4'h0;
      bus.mem_addr  = {AW{1'b0}};
      bus.mem_wdata = {DW{1'b0}};
      bus.if_ack    = 1'b0;
      bus.d_ack     = 1'b0;
      bus.if_rdata  = bus.mem_rdata;
      bus.d_rdata   = bus.mem_rdata;
      err           = 1'b0;
      case (state_r)
         GRANT_I: begin
            bus.mem_req  = 1'b1;
            bus.mem_be   = 4'hF;
            bus.mem_addr = bus.if_addr;
            bus.if_ack   = rst_n && done_s;
            err          = rst_n && tmo_s;
            if (tmo_s) begin
               bus.if_rdata = {DW{1'b0}};
            end else begin
               bus.if_rdata = bus.mem_rdata;
            end
         end
         GRANT_D: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_be;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.d_ack     = rst_n && done_s;
            err           = rst_n && tmo_s;
            if (tmo_s) begin
               bus.d_rdata = {DW{1'b0}};
            end else begin
               bus.d_rdata = bus.mem_rdata;
            end
         end
         default: begin
            bus.mem_req = 1'b0;
         end
      endcase
   end

   assign sel  = sel_r;
   assign busy = granted_s;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;
   localparam logic [31:0] RD = 32'h0050_0093;

   logic clk = 1'b0;
   logic rst_n;
   logic sel, busy, err;
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .sel   (sel),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   // {rst_n, if_req, d_req, mem_ack, exp mem_req, exp sel, exp if_ack, exp d_ack, exp busy}
   typedef struct packed {
      logic rst_n, ifr, dr, ack;
      logic e_mreq, e_sel, e_ia, e_da, e_busy;
   } vec_t;
   vec_t tbl [22];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input bit e_mreq, input bit e_sel, input bit e_busy,
                            input bit e_ia, input bit e_da, input bit e_err,
                            input logic [31:0] e_addr, input bit e_we, input logic [3:0] e_be,
                            input logic [31:0] e_wdata, input logic [31:0] e_ird,
                            input logic [31:0] e_drd);
      chk({tag, ".mem_req"}, 64'(bus.mem_req), 64'(e_mreq));
      chk({tag, ".sel"},     64'(sel),         64'(e_sel));
      chk({tag, ".busy"},    64'(busy),        64'(e_busy));
      chk({tag, ".if_ack"},  64'(bus.if_ack),  64'(e_ia));
      chk({tag, ".d_ack"},   64'(bus.d_ack),   64'(e_da));
      chk({tag, ".err"},     64'(err),         64'(e_err));
      if (e_mreq) begin
         chk({tag, ".mem_addr"},  64'(bus.mem_addr),  64'(e_addr));
         chk({tag, ".mem_we"},    64'(bus.mem_we),    64'(e_we));
         chk({tag, ".mem_be"},    64'(bus.mem_be),    64'(e_be));
         chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(e_wdata));
      end
      if (e_ia) chk({tag, ".if_rdata"}, 64'(bus.if_rdata), 64'(e_ird));
      if (e_da) chk({tag, ".d_rdata"},  64'(bus.d_rdata),  64'(e_drd));
   endtask

   task automatic clear_inputs();
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // reference model state: grant 0 none / 1 fetch / 2 data; last 1 fetch / 2 data
   int   m_grant, m_last, m_wait;
   bit   m_sel, f_pend, d_pend, ack;
   int   stall;

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      tbl[0]  = 9'b0000_00000;
      tbl[1]  = 9'b1100_00000;
      tbl[2]  = 9'b1100_10001;
      tbl[3]  = 9'b1101_10101;
      tbl[4]  = 9'b1000_00000;
      tbl[5]  = 9'b1001_00000;
      tbl[6]  = 9'b1010_00000;
      tbl[7]  = 9'b1011_11011;
      tbl[8]  = 9'b1000_01000;
      tbl[9]  = 9'b1010_01000;
      tbl[10] = 9'b0011_11001;
      tbl[11] = 9'b1000_00000;
      tbl[12] = 9'b0000_00000;
      tbl[13] = 9'b1110_00000;
      tbl[14] = 9'b1111_10101;
      tbl[15] = 9'b1110_00000;
      tbl[16] = 9'b1111_11011;
      tbl[17] = 9'b1110_01000;
      tbl[18] = 9'b1111_10101;
      tbl[19] = 9'b1110_00000;
      tbl[20] = 9'b1111_11011;
      tbl[21] = 9'b1000_01000;

      repeat (3) @(posedge clk);

      // directed table: fixed fetch at 0x100, fixed store to 0x2000
      bus.if_addr = 32'h100; bus.d_addr = 32'h2000; bus.d_we = 1'b1; bus.d_be = 4'b0011;
      bus.d_wdata = 32'hDEAD_BEEF; bus.mem_rdata = RD;
      for (int i = 0; i < 22; i++) begin
         @(posedge clk); #1;
         rst_n = tbl[i].rst_n; bus.if_req = tbl[i].ifr; bus.d_req = tbl[i].dr; bus.mem_ack = tbl[i].ack;
         #3;
         check_all($sformatf("vec%0d", i), tbl[i].e_mreq, tbl[i].e_sel, tbl[i].e_busy, tbl[i].e_ia,
                   tbl[i].e_da, 1'b0, tbl[i].e_sel ? 32'h2000 : 32'h100, tbl[i].e_sel,
                   tbl[i].e_sel ? 4'b0011 : 4'hF, tbl[i].e_sel ? 32'hDEAD_BEEF : 32'h0, RD, RD);
      end

      // fetch drops its request mid-grant: grant is held until the memory acks
      do_reset();
      bus.if_addr = 32'h400; bus.mem_rdata = 32'hCAFE_0001;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         bus.if_req  = (c == 0);
         bus.mem_ack = (c == 4);
         #3;
         check_all($sformatf("drop%0d", c), (c >= 1 && c <= 4), 1'b0, (c >= 1 && c <= 4),
                   (c == 4), 1'b0, 1'b0, 32'h400, 1'b0, 4'hF, 32'h0, 32'hCAFE_0001, 32'h0);
      end

`ifdef ARB_TIMEOUT_EN
      // timeout abort after TMO cycles, then the same with mem_ack winning in the last cycle
      for (int run = 0; run < 2; run++) begin
         do_reset();
         bus.d_addr = 32'h3000; bus.d_be = 4'hF; bus.mem_rdata = 32'h1234_5678;
         @(posedge clk); #1;
         bus.d_req = 1'b1;
         #3;
         check_all($sformatf("tmo%0d.idle", run), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
         for (int g = 0; g <= TMO; g++) begin
            @(posedge clk); #1;
            bus.mem_ack = (run == 1) && (g == TMO);
            #3;
            check_all($sformatf("tmo%0d.g%0d", run, g), 1'b1, 1'b1, 1'b1, 1'b0, (g == TMO),
                      (run == 0) && (g == TMO), 32'h3000, 1'b0, 4'hF, 32'h0, 32'h0,
                      (run == 0) ? 32'h0 : 32'h1234_5678);
         end
         @(posedge clk); #1;
         bus.d_req = 1'b0; bus.mem_ack = 1'b0;
         #3;
         check_all($sformatf("tmo%0d.after", run), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      end
`else
      // without the timeout a grant waits indefinitely
      do_reset();
      bus.d_addr = 32'h3000; bus.d_be = 4'hF; bus.mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus.d_req = 1'b1;
      stall = 0;
      for (int c = 0; c < 1100; c++) begin
         @(posedge clk); #4;
         if (bus.mem_req && !bus.d_ack && !err) stall++;
      end
      chk("nowait.held_cycles", 64'(stall), 64'd1100);
      @(posedge clk); #1;
      bus.mem_ack = 1'b1;
      #3;
      check_all("nowait.ack", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3000, 1'b0, 4'hF, 32'h0,
                32'h0, 32'h1234_5678);
`endif

      // randomized traffic against the transaction-level model
      do_reset();
      m_grant = 0; m_last = 2; m_sel = 1'b0; m_wait = 0; f_pend = 1'b0; d_pend = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (!f_pend && $urandom_range(0, 2) == 0) begin
            f_pend = 1'b1; bus.if_addr = $urandom;
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1'b1; bus.d_addr = $urandom; bus.d_we = 1'($urandom_range(0, 1));
            bus.d_be = 4'($urandom); bus.d_wdata = $urandom;
         end
         bus.if_req = f_pend; bus.d_req = d_pend;
         if (m_grant != 0) ack = (m_wait >= 3) || ($urandom_range(0, 1) == 1);
         else              ack = ($urandom_range(0, 3) == 0);
         bus.mem_ack = ack; bus.mem_rdata = $urandom;
         #3;
         check_all($sformatf("rnd%0d", c), m_grant != 0, m_sel, m_grant != 0,
                   (m_grant == 1) && ack, (m_grant == 2) && ack, 1'b0,
                   (m_grant == 2) ? bus.d_addr : bus.if_addr, (m_grant == 2) && bus.d_we,
                   (m_grant == 2) ? bus.d_be : 4'hF, (m_grant == 2) ? bus.d_wdata : 32'h0,
                   bus.mem_rdata, bus.mem_rdata);
         if (m_grant == 0) begin
            if (f_pend && d_pend) m_grant = (m_last == 2) ? 1 : 2;
            else if (f_pend)      m_grant = 1;
            else if (d_pend)      m_grant = 2;
            if (m_grant != 0) m_sel = (m_grant == 2);
            m_wait = 0;
         end else if (ack) begin
            m_last = m_grant;
            if (m_grant == 1) f_pend = 1'b0;
            else              d_pend = 1'b0;
            m_grant = 0;
         end else begin
            m_wait++;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
